ws2812_frame_receiver: RTL and testbench



---
 rtl/ws2812_pkg.sv | 24 ++
 rtl/ws2812_bit_decoder.sv | 129 ++++++++++++
 rtl/ws2812_frame_receiver.sv | 172 +++++++++++++++++
 tb/tb_ws2812_frame_receiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants for the WS2812 single-wire LED link, used by both the
// transmitter and the loopback receiver.
package ws2812_pkg;

   localparam int T0H             = 20;
   localparam int T1H             = 40;
   localparam int BIT_THRESHOLD   = 30;
   localparam int MAX_HIGH_CYCLES = 100;
   localparam int RESET_CYCLES    = 2500;
   localparam int FRAME_W         = 24;

   localparam logic [1:0] ERR_NONE      = 2'b00;
   localparam logic [1:0] ERR_LONG_HIGH = 2'b01;
   localparam logic [1:0] ERR_PARTIAL   = 2'b10;
   localparam logic [1:0] ERR_OVERRUN   = 2'b11;

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      IDLE = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } ws_state_e;

endpackage

// File: rtl/ws2812_bit_decoder.sv
// Synchronizes the serial line, measures high/low pulse widths and emits
// one-cycle bit, latch and long-high events.
module ws2812_bit_decoder
   import ws2812_pkg::*;
#(
   parameter int BIT_THR   = 30,
   parameter int MAX_HIGH  = 100,
   parameter int RESET_CYC = 2500
) (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic bit_valid,
   output logic bit_value,
   output logic latch,
   output logic long_high
);

   localparam int CNT_MAX = (RESET_CYC > MAX_HIGH) ? RESET_CYC : MAX_HIGH;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic             sync1_q, sync2_q, prev_q;
   ws_state_e        state_q, state_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
   logic [CNT_W-1:0] hinc, linc;
   logic             bit_valid_q, bit_valid_d;
   logic             bit_value_q, bit_value_d;
   logic             latch_q, latch_d;
   logic             long_high_q, long_high_d;
   logic             rise, fall;

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;

   assign hinc = (&hcnt_q) ? hcnt_q : hcnt_q + CNT_W'(1);
   assign linc = (&lcnt_q) ? lcnt_q : lcnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      hcnt_d      = hcnt_q;
      lcnt_d      = lcnt_q;
      bit_valid_d = 1'b0;
      bit_value_d = 1'b0;
      latch_d     = 1'b0;
      long_high_d = 1'b0;
      case (state_q)
         ARM: begin
            if (sync2_q) begin
               lcnt_d = '0;
            end else if (linc >= CNT_W'(RESET_CYC)) begin
               lcnt_d  = '0;
               state_d = IDLE;
            end else begin
               lcnt_d = linc;
            end
         end
         IDLE: begin
            if (rise) begin
               hcnt_d  = '0;
               state_d = HIGH;
            end
         end
         HIGH: begin
            // The limit check wins over a coincident falling edge.
            if (hinc >= CNT_W'(MAX_HIGH)) begin
               long_high_d = 1'b1;
               hcnt_d      = '0;
               lcnt_d      = '0;
               state_d     = ARM;
            end else if (fall) begin
               bit_valid_d = 1'b1;
               bit_value_d = (hinc >= CNT_W'(BIT_THR));
               lcnt_d      = CNT_W'(1);
               state_d     = LOW;
            end else begin
               hcnt_d = hinc;
            end
         end
         LOW: begin
            if (rise) begin
               hcnt_d  = '0;
               state_d = HIGH;
            end else if (linc >= CNT_W'(RESET_CYC)) begin
               latch_d = 1'b1;
               lcnt_d  = '0;
               state_d = IDLE;
            end else begin
               lcnt_d = linc;
            end
         end
         default: begin
            lcnt_d  = '0;
            state_d = ARM;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         prev_q      <= 1'b0;
         state_q     <= ARM;
         hcnt_q      <= '0;
         lcnt_q      <= '0;
         bit_valid_q <= 1'b0;
         bit_value_q <= 1'b0;
         latch_q     <= 1'b0;
         long_high_q <= 1'b0;
      end else begin
         sync1_q     <= din;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         lcnt_q      <= lcnt_d;
         bit_valid_q <= bit_valid_d;
         bit_value_q <= bit_value_d;
         latch_q     <= latch_d;
         long_high_q <= long_high_d;
      end
   end

   assign bit_valid = bit_valid_q;
   assign bit_value = bit_value_q;
   assign latch     = latch_q;
   assign long_high = long_high_q;

endmodule

// File: rtl/ws2812_frame_receiver.sv
// WS2812 loopback receiver: assembles decoded bits into 24-bit frames per LED.
// Define WS2812_FRAME_BANK_EN to add a per-set frame_bank output.
module ws2812_frame_receiver #(
   parameter int NUM_LEDS        = 8,
   parameter int BIT_THRESHOLD   = ws2812_pkg::BIT_THRESHOLD,
   parameter int MAX_HIGH_CYCLES = ws2812_pkg::MAX_HIGH_CYCLES,
   parameter int RESET_CYCLES    = ws2812_pkg::RESET_CYCLES,
   localparam int IDX_W          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
   localparam int FC_W           = $clog2(NUM_LEDS + 1)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       din,
   output logic [23:0]                frame_out,
   output logic                       frame_valid,
   output logic [IDX_W-1:0]           frame_idx,
   output logic                       set_done,
   output logic [FC_W-1:0]            frames_in_set,
`ifdef WS2812_FRAME_BANK_EN
   output logic [NUM_LEDS*24-1:0]     frame_bank,
`endif
   output logic                       err,
   output logic [1:0]                 err_code
);

   import ws2812_pkg::*;

   localparam int BC_W = $clog2(FRAME_W);

   logic bit_valid, bit_value, latch, long_high;

   ws2812_bit_decoder #(
      .BIT_THR   (BIT_THRESHOLD),
      .MAX_HIGH  (MAX_HIGH_CYCLES),
      .RESET_CYC (RESET_CYCLES)
   ) u_dec (
      .clk       (clk),
      .rstn      (rstn),
      .din       (din),
      .bit_valid (bit_valid),
      .bit_value (bit_value),
      .latch     (latch),
      .long_high (long_high)
   );

   logic [FRAME_W-2:0] shift_q, shift_d;
   logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
   logic               ovr_q, ovr_d;
   logic [FRAME_W-1:0] frame_out_q, frame_out_d;
   logic               frame_valid_q, frame_valid_d;
   logic [IDX_W-1:0]   frame_idx_q, frame_idx_d;
   logic               set_done_q, set_done_d;
   logic [FC_W-1:0]    fis_q, fis_d;
   logic               err_q, err_d;
   logic [1:0]         err_code_q, err_code_d;
   logic [FRAME_W-1:0] word;
`ifdef WS2812_FRAME_BANK_EN
   logic [NUM_LEDS-1:0][FRAME_W-1:0] shadow_q, shadow_d, bank_q, bank_d;
`endif

   assign word = {shift_q, bit_value};

   always_comb begin
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      frame_cnt_d   = frame_cnt_q;
      ovr_d         = ovr_q;
      frame_out_d   = frame_out_q;
      frame_valid_d = 1'b0;
      frame_idx_d   = frame_idx_q;
      set_done_d    = 1'b0;
      fis_d         = fis_q;
      err_d         = 1'b0;
      err_code_d    = err_code_q;
`ifdef WS2812_FRAME_BANK_EN
      shadow_d      = shadow_q;
      bank_d        = bank_q;
`endif
      if (long_high) begin
         err_d       = 1'b1;
         err_code_d  = ERR_LONG_HIGH;
         shift_d     = '0;
         bit_cnt_d   = '0;
         frame_cnt_d = '0;
         ovr_d       = 1'b0;
      end else if (latch) begin
         set_done_d = 1'b1;
         fis_d      = (frame_cnt_q > FC_W'(NUM_LEDS)) ? FC_W'(NUM_LEDS) : frame_cnt_q;
         if (bit_cnt_q != '0) begin
            err_d      = 1'b1;
            err_code_d = ERR_PARTIAL;
         end
         shift_d     = '0;
         bit_cnt_d   = '0;
         frame_cnt_d = '0;
         ovr_d       = 1'b0;
`ifdef WS2812_FRAME_BANK_EN
         bank_d      = shadow_q;
`endif
      end else if (bit_valid) begin
         shift_d = word[FRAME_W-2:0];
         if (bit_cnt_q == BC_W'(FRAME_W - 1)) begin
            bit_cnt_d = '0;
            if (frame_cnt_q < FC_W'(NUM_LEDS)) begin
               frame_out_d   = word;
               frame_idx_d   = frame_cnt_q[IDX_W-1:0];
               frame_valid_d = 1'b1;
               frame_cnt_d   = frame_cnt_q + FC_W'(1);
`ifdef WS2812_FRAME_BANK_EN
               shadow_d[frame_cnt_q[IDX_W-1:0]] = word;
`endif
            end else if (!ovr_q) begin
               // Overrun is flagged once; later extra frames are dropped silently.
               err_d      = 1'b1;
               err_code_d = ERR_OVERRUN;
               ovr_d      = 1'b1;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         frame_cnt_q   <= '0;
         ovr_q         <= 1'b0;
         frame_out_q   <= '0;
         frame_valid_q <= 1'b0;
         frame_idx_q   <= '0;
         set_done_q    <= 1'b0;
         fis_q         <= '0;
         err_q         <= 1'b0;
         err_code_q    <= ERR_NONE;
`ifdef WS2812_FRAME_BANK_EN
         shadow_q      <= '0;
         bank_q        <= '0;
`endif
      end else begin
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         ovr_q         <= ovr_d;
         frame_out_q   <= frame_out_d;
         frame_valid_q <= frame_valid_d;
         frame_idx_q   <= frame_idx_d;
         set_done_q    <= set_done_d;
         fis_q         <= fis_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
`ifdef WS2812_FRAME_BANK_EN
         shadow_q      <= shadow_d;
         bank_q        <= bank_d;
`endif
      end
   end

   assign frame_out     = frame_out_q;
   assign frame_valid   = frame_valid_q;
   assign frame_idx     = frame_idx_q;
   assign set_done      = set_done_q;
   assign frames_in_set = fis_q;
   assign err           = err_q;
   assign err_code      = err_code_q;
`ifdef WS2812_FRAME_BANK_EN
   assign frame_bank    = bank_q;
`endif

endmodule

// File: tb/tb_ws2812_frame_receiver.sv
// Directed/randomized bench for ws2812_frame_receiver with a frame-level model.
module tb_ws2812_frame_receiver;

   logic        clk = 1'b0;
   logic        rstn;
   logic        din;
   logic [23:0] frame_out;
   logic        frame_valid;
   logic [2:0]  frame_idx;
   logic        set_done;
   logic [3:0]  frames_in_set;
   logic        err;
   logic [1:0]  err_code;
`ifdef WS2812_FRAME_BANK_EN
   logic [8*24-1:0] frame_bank;
`endif

   int nchecks = 0;
   int nerrs   = 0;

   logic [23:0] mon_frame[$];
   logic [2:0]  mon_idx[$];
   logic [3:0]  mon_fis[$];
   logic [2:0]  mon_sderr[$];
   logic [1:0]  mon_err[$];
   logic [23:0] exp_f[$];

   always #5 clk = ~clk;

   ws2812_frame_receiver dut (
      .clk           (clk),
      .rstn          (rstn),
      .din           (din),
      .frame_out     (frame_out),
      .frame_valid   (frame_valid),
      .frame_idx     (frame_idx),
      .set_done      (set_done),
      .frames_in_set (frames_in_set),
`ifdef WS2812_FRAME_BANK_EN
      .frame_bank    (frame_bank),
`endif
      .err           (err),
      .err_code      (err_code)
   );

   always @(negedge clk) begin
      if (rstn) begin
         if (frame_valid) begin
            mon_frame.push_back(frame_out);
            mon_idx.push_back(frame_idx);
         end
         if (set_done) begin
            mon_fis.push_back(frames_in_set);
            mon_sderr.push_back({err, err_code});
         end
         if (err) mon_err.push_back(err_code);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int hi, input int lo);
      din = 1'b1;
      cyc(hi);
      din = 1'b0;
      cyc(lo);
   endtask

   task automatic send_bit(input logic b);
      if (b) pulse(40, 22);
      else   pulse(20, 42);
   endtask

   task automatic send_frame(input logic [23:0] f);
      for (int i = 23; i >= 0; i--) send_bit(f[i]);
   endtask

   task automatic clear_mon();
      mon_frame.delete();
      mon_idx.delete();
      mon_fis.delete();
      mon_sderr.delete();
      mon_err.delete();
      exp_f.delete();
   endtask

   // Frames received must be the first min(sent, 8) frames, indexed in order.
   task automatic check_frames(input string tag);
      int n;
      n = (exp_f.size() > 8) ? 8 : exp_f.size();
      check({tag, "_count"}, mon_frame.size(), n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_data"}, (i < mon_frame.size()) ? {8'h0, mon_frame[i]} : 32'hxxxxxxxx,
               {8'h0, exp_f[i]});
         check({tag, "_idx"}, (i < mon_idx.size()) ? {29'h0, mon_idx[i]} : 32'hxxxxxxxx, i);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_frame_out"}, {8'h0, frame_out}, 0);
      check({tag, "_valid"}, {31'h0, frame_valid}, 0);
      check({tag, "_idx"}, {29'h0, frame_idx}, 0);
      check({tag, "_set_done"}, {31'h0, set_done}, 0);
      check({tag, "_fis"}, {28'h0, frames_in_set}, 0);
      check({tag, "_err"}, {31'h0, err}, 0);
      check({tag, "_err_code"}, {30'h0, err_code}, 0);
   endtask

   initial begin
      logic [23:0] f;
      int          w, lo;

      rstn = 1'b0;
      din  = 1'b0;
      cyc(3);
      check_idle_outputs("reset");
      rstn = 1'b1;
      cyc(2600);

      // Single known frame
      clear_mon();
      exp_f.push_back(24'hFF0000);
      send_frame(24'hFF0000);
      cyc(10);
      check_frames("single");
      cyc(2600);
      check("single_sd_count", mon_fis.size(), 1);
      check("single_fis", {28'h0, mon_fis[0]}, 1);
      check("single_noerr", mon_err.size(), 0);

      // Full set of random frames
      clear_mon();
      for (int i = 0; i < 8; i++) begin
         f = 24'($urandom);
         exp_f.push_back(f);
         send_frame(f);
      end
      cyc(2600);
      check_frames("set8");
      check("set8_sd_count", mon_fis.size(), 1);
      check("set8_fis", {28'h0, mon_fis[0]}, 8);
      check("set8_sd_err", {29'h0, mon_sderr[0]}, 0);
      check("set8_noerr", mon_err.size(), 0);
`ifdef WS2812_FRAME_BANK_EN
      for (int i = 0; i < 8; i++)
         check("bank", {8'h0, frame_bank[i*24 +: 24]}, {8'h0, exp_f[i]});
`endif

      // Random pulse widths around the decode threshold and long-high limit
      clear_mon();
      f = '0;
      for (int i = 0; i < 24; i++) begin
         case (i)
            0: w = 29;
            1: w = 30;
            2: w = 99;
            3: w = 20;
            default: w = $urandom_range(20, 99);
         endcase
         lo = $urandom_range(3, 60);
         f = {f[22:0], (w >= 30)};
         pulse(w, lo);
      end
      exp_f.push_back(f);
      cyc(2600);
      check_frames("thresh");
      check("thresh_fis", {28'h0, mon_fis[0]}, 1);
      check("thresh_noerr", mon_err.size(), 0);

      // Stuck-high line mid-frame
      clear_mon();
      for (int i = 0; i < 10; i++) send_bit(1'($urandom));
      pulse(100, 20);
      check("lh_err_count", mon_err.size(), 1);
      check("lh_err_code", {30'h0, mon_err[0]}, 1);
      check("lh_code_hold", {30'h0, err_code}, 1);
      check("lh_no_valid", mon_frame.size(), 0);
      cyc(2600);
      check("lh_arm_no_sd", mon_fis.size(), 0);
      f = 24'($urandom);
      exp_f.push_back(f);
      send_frame(f);
      cyc(2600);
      check_frames("lh_after");
      check("lh_after_fis", {28'h0, mon_fis[0]}, 1);

      // Partial frame at latch
      clear_mon();
      for (int i = 0; i < 10; i++) send_bit(1'($urandom));
      cyc(2600);
      check("part_sd_count", mon_fis.size(), 1);
      check("part_fis", {28'h0, mon_fis[0]}, 0);
      check("part_sd_err", {29'h0, mon_sderr[0]}, 3'b110);
      check("part_no_valid", mon_frame.size(), 0);

      // Overrun: ten frames into an eight-LED set
      clear_mon();
      for (int i = 0; i < 10; i++) begin
         f = 24'($urandom);
         exp_f.push_back(f);
         send_frame(f);
      end
      cyc(10);
      check_frames("ovr");
      check("ovr_err_count", mon_err.size(), 1);
      check("ovr_err_code", {30'h0, mon_err[0]}, 3);

      // Reset mid-frame, then re-arm
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      din = 1'b1;
      cyc(10);
      rstn = 1'b0;
      cyc(2);
      check_idle_outputs("midrst");
      rstn = 1'b1;
      cyc(5);
      din = 1'b0;
      cyc(30);
      clear_mon();
      send_frame(24'($urandom));
      cyc(2600);
      check("rearm_ignored", mon_frame.size(), 0);
      check("rearm_no_sd", mon_fis.size(), 0);
      f = 24'($urandom);
      exp_f.push_back(f);
      send_frame(f);
      cyc(2600);
      check_frames("rearm");
      check("rearm_fis", {28'h0, mon_fis[0]}, 1);
      check("rearm_noerr", mon_err.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

endmodule
